// File: rtl/smart_pkg.sv
// Shared types and constants for the safe-region access controller.
package smart_pkg;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MEM_W   = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned REG_NUM = 6;

    // Register word offsets from BASE_ADDR
    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_SAFE_LO = 3'd1;
    localparam logic [2:0] OFF_SAFE_HI = 3'd2;
    localparam logic [2:0] OFF_CODE_LO = 3'd3;
    localparam logic [2:0] OFF_CODE_HI = 3'd4;
    localparam logic [2:0] OFF_STATUS  = 3'd5;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_LOCK    = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned STAT_FLAG    = 0;
    localparam int unsigned STAT_CNT_CLR = 1;
    localparam int unsigned STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_OUTSIDE  = 2'd1,
        ST_INSIDE   = 2'd2,
        ST_VIOL     = 2'd3
    } state_e;

    // Configuration the FSM consumes from the register block
    typedef struct packed {
        logic              en;
        logic [MEM_W-1:0]  safe_lo;
        logic [MEM_W-1:0]  safe_hi;
        logic [MEM_W-1:0]  code_lo;
        logic [MEM_W-1:0]  code_hi;
    } cfg_t;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] din,
        input logic [1:0]        we
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        if (we[0]) res[7:0]  = din[7:0];
        if (we[1]) res[15:8] = din[15:8];
        return res;
    endfunction

endpackage

// File: rtl/safe_region_regs.sv
// Peripheral register block: address decode, byte-granular writes with LOCK
// gating, violation flag/count bookkeeping and the combinational read mux.
module safe_region_regs
    import smart_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h0048
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_per_addr,
    input  logic [DATA_W-1:0] i_per_din,
    input  logic              i_per_en,
    input  logic [1:0]        i_per_we,
    output logic [DATA_W-1:0] o_per_dout,
    input  logic              i_viol_set,
    output cfg_t              o_cfg,
    output logic              o_irq_violation
);

    logic [ADDR_W-1:0] w_offset;
    logic [2:0]        w_sel;
    logic              w_hit;
    logic              w_wr;
    logic              w_rd;

    logic              r_en;
    logic              r_lock;
    logic              r_irq_en;
    logic [MEM_W-1:0]  r_safe_lo;
    logic [MEM_W-1:0]  r_safe_hi;
    logic [MEM_W-1:0]  r_code_lo;
    logic [MEM_W-1:0]  r_code_hi;
    logic              r_flag;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_irq;

    logic              w_en_nxt;
    logic              w_lock_nxt;
    logic              w_irq_en_nxt;
    logic [MEM_W-1:0]  w_safe_lo_nxt;
    logic [MEM_W-1:0]  w_safe_hi_nxt;
    logic [MEM_W-1:0]  w_code_lo_nxt;
    logic [MEM_W-1:0]  w_code_hi_nxt;
    logic              w_flag_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_clr_flag;
    logic              w_clr_cnt;

    assign w_offset = i_per_addr - BASE_ADDR;
    assign w_hit    = (i_per_addr >= BASE_ADDR) && (w_offset < ADDR_W'(REG_NUM));
    assign w_sel    = w_offset[2:0];
    assign w_wr     = i_per_en && (i_per_we != 2'b00) && w_hit;
    assign w_rd     = i_per_en && (i_per_we == 2'b00) && w_hit;

    // Register next values; a locked block only accepts IRQ_EN and STATUS
    always_comb begin
        w_en_nxt      = r_en;
        w_lock_nxt    = r_lock;
        w_irq_en_nxt  = r_irq_en;
        w_safe_lo_nxt = r_safe_lo;
        w_safe_hi_nxt = r_safe_hi;
        w_code_lo_nxt = r_code_lo;
        w_code_hi_nxt = r_code_hi;
        w_clr_flag    = 1'b0;
        w_clr_cnt     = 1'b0;
        if (w_wr) begin
            case (w_sel)
                OFF_CTRL: begin
                    if (i_per_we[0]) begin
                        if (!r_lock) begin
                            w_en_nxt   = i_per_din[CTRL_EN];
                            w_lock_nxt = i_per_din[CTRL_LOCK];
                        end
                        w_irq_en_nxt = i_per_din[CTRL_IRQ_EN];
                    end
                end
                OFF_SAFE_LO: if (!r_lock) w_safe_lo_nxt = byte_merge(r_safe_lo, i_per_din, i_per_we);
                OFF_SAFE_HI: if (!r_lock) w_safe_hi_nxt = byte_merge(r_safe_hi, i_per_din, i_per_we);
                OFF_CODE_LO: if (!r_lock) w_code_lo_nxt = byte_merge(r_code_lo, i_per_din, i_per_we);
                OFF_CODE_HI: if (!r_lock) w_code_hi_nxt = byte_merge(r_code_hi, i_per_din, i_per_we);
                OFF_STATUS: begin
                    if (i_per_we[0]) begin
                        w_clr_flag = i_per_din[STAT_FLAG];
                        w_clr_cnt  = i_per_din[STAT_CNT_CLR];
                    end
                end
                default: ;
            endcase
        end

        // A violation entry beats a same-cycle software clear
        if (i_viol_set) begin
            w_flag_nxt = 1'b1;
            if (w_clr_cnt)
                w_cnt_nxt = CNT_W'(1);
            else if (r_cnt == {CNT_W{1'b1}})
                w_cnt_nxt = r_cnt;
            else
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_flag_nxt = w_clr_flag ? 1'b0 : r_flag;
            w_cnt_nxt  = w_clr_cnt ? '0 : r_cnt;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= 1'b0;
            r_lock    <= 1'b0;
            r_irq_en  <= 1'b0;
            r_safe_lo <= '0;
            r_safe_hi <= '0;
            r_code_lo <= '0;
            r_code_hi <= '0;
            r_flag    <= 1'b0;
            r_cnt     <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_en      <= w_en_nxt;
            r_lock    <= w_lock_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_safe_lo <= w_safe_lo_nxt;
            r_safe_hi <= w_safe_hi_nxt;
            r_code_lo <= w_code_lo_nxt;
            r_code_hi <= w_code_hi_nxt;
            r_flag    <= w_flag_nxt;
            r_cnt     <= w_cnt_nxt;
            r_irq     <= w_flag_nxt & w_irq_en_nxt;
        end
    end

    // Combinational read data, zero unless a read hits the map
    always_comb begin
        o_per_dout = '0;
        if (w_rd) begin
            case (w_sel)
                OFF_CTRL: begin
                    o_per_dout[CTRL_EN]     = r_en;
                    o_per_dout[CTRL_LOCK]   = r_lock;
                    o_per_dout[CTRL_IRQ_EN] = r_irq_en;
                end
                OFF_SAFE_LO: o_per_dout = r_safe_lo;
                OFF_SAFE_HI: o_per_dout = r_safe_hi;
                OFF_CODE_LO: o_per_dout = r_code_lo;
                OFF_CODE_HI: o_per_dout = r_code_hi;
                OFF_STATUS: begin
                    o_per_dout[STAT_FLAG]                 = r_flag;
                    o_per_dout[STAT_CNT_LSB +: CNT_W]     = r_cnt;
                end
                default: o_per_dout = '0;
            endcase
        end
    end

    assign o_cfg.en        = r_en;
    assign o_cfg.safe_lo   = r_safe_lo;
    assign o_cfg.safe_hi   = r_safe_hi;
    assign o_cfg.code_lo   = r_code_lo;
    assign o_cfg.code_hi   = r_code_hi;
    assign o_irq_violation = r_irq;

endmodule

// File: rtl/safe_region_ctrl.sv
// Safe-region access controller: single-entry-point sequencing of protected
// code, illegal-access detection and a stretched violation reset.
module safe_region_ctrl
    import smart_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h0048,
    parameter int unsigned       RST_PULSE = 8
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [DATA_W-1:0] per_dout,
    input  logic [MEM_W-1:0]  mem_addr,
    input  logic              mem_en,
    input  logic [MEM_W-1:0]  pc,
    input  logic              pc_valid,
    input  logic              disable_debug,
    output logic              in_safe_area,
    output logic              violation_rst,
    output logic              irq_violation
);

    localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE - 1);

    cfg_t       w_cfg;
    logic       w_viol_set;
    logic       w_addr_in_safe;
    logic       w_pc_in_code;
    logic       w_pc_entry;
    state_e     r_state;
    state_e     w_state_nxt;
    logic [7:0] r_pulse_cnt;
    logic [7:0] w_pulse_nxt;
    logic       r_in_safe;
    logic       r_viol_rst;

    safe_region_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .mclk            (mclk),
        .reset_n         (reset_n),
        .i_per_addr      (per_addr),
        .i_per_din       (per_din),
        .i_per_en        (per_en),
        .i_per_we        (per_we),
        .o_per_dout      (per_dout),
        .i_viol_set      (w_viol_set),
        .o_cfg           (w_cfg),
        .o_irq_violation (irq_violation)
    );

    // Inclusive unsigned range checks; lo > hi yields an empty range
    assign w_addr_in_safe = mem_en && (mem_addr >= w_cfg.safe_lo) && (mem_addr <= w_cfg.safe_hi);
    assign w_pc_in_code   = pc_valid && (pc >= w_cfg.code_lo) && (pc <= w_cfg.code_hi);
    assign w_pc_entry     = pc_valid && (pc == w_cfg.code_lo);

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = r_pulse_cnt;
        w_viol_set  = 1'b0;
        case (r_state)
            ST_DISABLED: begin
                if (w_cfg.en) w_state_nxt = ST_OUTSIDE;
            end
            ST_OUTSIDE: begin
                // Data intrusion outranks a same-cycle entry fetch
                if (w_addr_in_safe) begin
                    w_state_nxt = ST_VIOL;
                    w_pulse_nxt = PULSE_LOAD;
                end else if (w_pc_entry) begin
                    w_state_nxt = ST_INSIDE;
                end else if (w_pc_in_code) begin
                    w_state_nxt = ST_VIOL;
                    w_pulse_nxt = PULSE_LOAD;
                end
            end
            ST_INSIDE: begin
                if (pc_valid && !w_pc_in_code) w_state_nxt = ST_OUTSIDE;
            end
            ST_VIOL: begin
                if (r_pulse_cnt == 8'd0)
                    w_state_nxt = ST_OUTSIDE;
                else
                    w_pulse_nxt = r_pulse_cnt - 8'd1;
            end
            default: w_state_nxt = ST_DISABLED;
        endcase

        if (!w_cfg.en) w_state_nxt = ST_DISABLED;

        w_viol_set = (r_state != ST_VIOL) && (w_state_nxt == ST_VIOL);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_DISABLED;
            r_pulse_cnt <= 8'd0;
            r_in_safe   <= 1'b0;
            r_viol_rst  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_in_safe   <= (w_state_nxt == ST_INSIDE);
            r_viol_rst  <= (w_state_nxt == ST_VIOL) && !disable_debug;
        end
    end

    assign in_safe_area  = r_in_safe;
    assign violation_rst = r_viol_rst;

endmodule

// File: tb/tb_safe_region_ctrl.sv
// Self-checking bench for safe_region_ctrl: register table, directed
// scenarios and a randomized run against a behavioural model.
module tb_safe_region_ctrl;

    localparam logic [13:0] BASE  = 14'h0048;
    localparam int          PULSE = 8;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] pc;
    logic        pc_valid;
    logic        disable_debug;
    logic        in_safe_area;
    logic        violation_rst;
    logic        irq_violation;

    int checks = 0;
    int errors = 0;

    safe_region_ctrl #(.BASE_ADDR(BASE), .RST_PULSE(PULSE)) dut (
        .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
        .mem_addr(mem_addr), .mem_en(mem_en), .pc(pc), .pc_valid(pc_valid),
        .disable_debug(disable_debug), .in_safe_area(in_safe_area),
        .violation_rst(violation_rst), .irq_violation(irq_violation)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        per_addr = a; per_din = d; per_we = we; per_en = 1'b1;
        cycle();
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic rd(input string nm, input logic [13:0] a, input logic [15:0] e);
        per_addr = a; per_we = 2'b00; per_en = 1'b1;
        #1;
        chk(nm, per_dout, e);
        per_en = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        per_addr = '0; per_din = '0; per_en = 0; per_we = 0;
        mem_addr = '0; mem_en = 0; pc = '0; pc_valid = 0; disable_debug = 0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_slo, m_shi, m_clo, m_chi;
    bit          m_en, m_lock, m_irqen, m_flag;
    int          m_cnt;
    int          m_mode;   // 0 off, 1 watching, 2 inside, 3 resetting
    int          m_left;   // reset cycles still to go
    bit          m_exp_rst;

    task automatic model_reset();
        m_slo = 0; m_shi = 0; m_clo = 0; m_chi = 0;
        m_en = 0; m_lock = 0; m_irqen = 0; m_flag = 0;
        m_cnt = 0; m_mode = 0; m_left = 0; m_exp_rst = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [13:0] a, input logic en, input logic [1:0] we);
        logic [13:0] o;
        o = a - BASE;
        if (!(en && we == 2'b00 && a >= BASE && o < 14'd6)) return 16'h0;
        case (o)
            14'd0: return {13'b0, m_irqen, m_lock, m_en};
            14'd1: return m_slo;
            14'd2: return m_shi;
            14'd3: return m_clo;
            14'd4: return m_chi;
            default: return {8'(m_cnt), 7'b0, m_flag};
        endcase
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] we);
        logic [15:0] r;
        r = o;
        if (we[0]) r[7:0] = d[7:0];
        if (we[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs presently driven
    task automatic model_edge();
        bit ais, inc, enter, clrf, clrc;
        int nmode, nleft;
        logic [13:0] o;
        ais = mem_en && mem_addr >= m_slo && mem_addr <= m_shi;
        inc = pc_valid && pc >= m_clo && pc <= m_chi;
        enter = 0; nmode = m_mode; nleft = m_left;
        if (!m_en) nmode = 0;
        else if (m_mode == 0) nmode = 1;
        else if (m_mode == 1) begin
            if (ais || (inc && pc != m_clo)) begin nmode = 3; nleft = PULSE; enter = 1; end
            else if (pc_valid && pc == m_clo) nmode = 2;
        end else if (m_mode == 2) begin
            if (pc_valid && !inc) nmode = 1;
        end else begin
            nleft = m_left - 1;
            if (nleft == 0) nmode = 1;
        end
        m_exp_rst = (nmode == 3) && !disable_debug;
        m_mode = nmode; m_left = nleft;

        clrf = 0; clrc = 0;
        o = per_addr - BASE;
        if (per_en && per_we != 0 && per_addr >= BASE && o < 14'd6) begin
            case (o)
                14'd0: if (per_we[0]) begin
                    if (!m_lock) begin m_en = per_din[0]; m_lock = per_din[1]; end
                    m_irqen = per_din[2];
                end
                14'd1: if (!m_lock) m_slo = merge(m_slo, per_din, per_we);
                14'd2: if (!m_lock) m_shi = merge(m_shi, per_din, per_we);
                14'd3: if (!m_lock) m_clo = merge(m_clo, per_din, per_we);
                14'd4: if (!m_lock) m_chi = merge(m_chi, per_din, per_we);
                default: if (per_we[0]) begin clrf = per_din[0]; clrc = per_din[1]; end
            endcase
        end
        if (enter) begin
            m_flag = 1;
            m_cnt = clrc ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
        end else begin
            if (clrf) m_flag = 0;
            if (clrc) m_cnt = 0;
        end
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic [13:0] addr;
        logic [1:0]  we;
        logic [15:0] din;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{BASE + 14'd1, 2'b11, 16'h0200, 16'h0000, "wr_safe_lo"};
        vt[1]  = '{BASE + 14'd1, 2'b00, 16'h0000, 16'h0200, "rd_safe_lo"};
        vt[2]  = '{BASE + 14'd2, 2'b01, 16'hABFF, 16'h0000, "wr_safe_hi_lo_byte"};
        vt[3]  = '{BASE + 14'd2, 2'b00, 16'h0000, 16'h00FF, "rd_safe_hi_lo_byte"};
        vt[4]  = '{BASE + 14'd2, 2'b10, 16'h02CD, 16'h0000, "wr_safe_hi_hi_byte"};
        vt[5]  = '{BASE + 14'd2, 2'b00, 16'h0000, 16'h02FF, "rd_safe_hi"};
        vt[6]  = '{BASE + 14'd3, 2'b11, 16'hE000, 16'h0000, "wr_code_lo"};
        vt[7]  = '{BASE + 14'd3, 2'b00, 16'h0000, 16'hE000, "rd_code_lo"};
        vt[8]  = '{BASE + 14'd4, 2'b11, 16'hE0FF, 16'h0000, "wr_code_hi"};
        vt[9]  = '{BASE + 14'd4, 2'b00, 16'h0000, 16'hE0FF, "rd_code_hi"};
        vt[10] = '{BASE + 14'd0, 2'b01, 16'h0005, 16'h0000, "wr_ctrl"};
        vt[11] = '{BASE + 14'd0, 2'b00, 16'h0000, 16'h0005, "rd_ctrl"};
        vt[12] = '{BASE + 14'd5, 2'b00, 16'h0000, 16'h0000, "rd_status_init"};
        vt[13] = '{BASE + 14'd6, 2'b00, 16'h0000, 16'h0000, "rd_past_map"};
        vt[14] = '{BASE - 14'd1, 2'b00, 16'h0000, 16'h0000, "rd_below_map"};
        vt[15] = '{BASE + 14'd0, 2'b10, 16'hFF00, 16'h0000, "wr_ctrl_hi_only"};
    end

    initial begin
        logic [15:0] e_dout;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        chk("reset_in_safe", in_safe_area, 0);
        chk("reset_viol_rst", violation_rst, 0);
        chk("reset_irq", irq_violation, 0);
        rd("reset_ctrl", BASE, 16'h0000);
        @(negedge mclk);
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 16; i++) begin
            if (vt[i].we != 2'b00) wr(vt[i].addr, vt[i].din, vt[i].we);
            else rd(vt[i].nm, vt[i].addr, vt[i].exp);
        end
        rd("rd_ctrl_after_hi_write", BASE, 16'h0005);
        cycle(); cycle();

        // Data intrusion from outside
        mem_en = 1; mem_addr = 16'h0210;
        cycle();
        mem_en = 0;
        chk("intrusion_irq", irq_violation, 1);
        chk("intrusion_in_safe", in_safe_area, 0);
        for (int i = 0; i < PULSE; i++) begin
            chk("intrusion_pulse_high", violation_rst, 1);
            cycle();
        end
        chk("intrusion_pulse_end", violation_rst, 0);
        rd("intrusion_status", BASE + 14'd5, 16'h0101);

        // Legal entry, in-region data access, exit
        pc_valid = 1; pc = 16'hE000;
        cycle();
        chk("entry_in_safe", in_safe_area, 1);
        pc = 16'hE004; mem_en = 1; mem_addr = 16'h0210;
        cycle();
        chk("inside_data_in_safe", in_safe_area, 1);
        chk("inside_data_no_rst", violation_rst, 0);
        mem_en = 0; pc = 16'h4400;
        cycle();
        pc_valid = 0;
        chk("exit_in_safe", in_safe_area, 0);
        rd("inside_status", BASE + 14'd5, 16'h0101);

        // Mid-region jump
        pc_valid = 1; pc = 16'hE010;
        cycle();
        pc_valid = 0;
        chk("midjump_rst", violation_rst, 1);
        repeat (PULSE) cycle();
        chk("midjump_end", violation_rst, 0);
        rd("midjump_status", BASE + 14'd5, 16'h0201);

        // Entry fetch plus data intrusion in the same cycle
        pc_valid = 1; pc = 16'hE000; mem_en = 1; mem_addr = 16'h0200;
        cycle();
        pc_valid = 0; mem_en = 0;
        chk("entry_vs_data_rst", violation_rst, 1);
        chk("entry_vs_data_in_safe", in_safe_area, 0);
        repeat (PULSE) cycle();
        rd("entry_vs_data_status", BASE + 14'd5, 16'h0301);

        // Clear racing a violation; repeated access while resetting not recounted
        mem_en = 1; mem_addr = 16'h02FF;
        per_en = 1; per_we = 2'b01; per_addr = BASE + 14'd5; per_din = 16'h0003;
        cycle();
        per_en = 0; per_we = 0;
        cycle(); cycle();
        mem_en = 0;
        repeat (PULSE - 2) cycle();
        chk("race_pulse_done", violation_rst, 0);
        rd("race_status", BASE + 14'd5, 16'h0101);

        // Range boundaries just outside
        mem_en = 1; mem_addr = 16'h0300;
        cycle();
        mem_addr = 16'h01FF;
        cycle();
        mem_en = 0;
        chk("boundary_no_rst", violation_rst, 0);

        // LOCK behaviour
        wr(BASE, 16'h0007, 2'b01);
        rd("lock_ctrl", BASE, 16'h0007);
        wr(BASE + 14'd1, 16'h0000, 2'b11);
        rd("lock_safe_lo", BASE + 14'd1, 16'h0200);
        wr(BASE, 16'h0004, 2'b11);
        rd("lock_ctrl_en_kept", BASE, 16'h0007);
        chk("lock_irq_before_clear", irq_violation, 1);
        wr(BASE + 14'd5, 16'h0001, 2'b11);
        chk("clear_flag_irq", irq_violation, 0);
        rd("clear_flag_status", BASE + 14'd5, 16'h0100);

        // disable_debug suppresses only the reset pulse
        disable_debug = 1; mem_en = 1; mem_addr = 16'h0250;
        cycle();
        mem_en = 0;
        for (int i = 0; i < PULSE + 1; i++) begin
            chk("dbg_no_rst", violation_rst, 0);
            cycle();
        end
        disable_debug = 0;
        rd("dbg_status", BASE + 14'd5, 16'h0201);
        chk("dbg_irq", irq_violation, 1);

        // Count saturation
        mem_en = 1; mem_addr = 16'h0210;
        repeat (256 * (PULSE + 1) + 20) cycle();
        mem_en = 0;
        repeat (PULSE + 2) cycle();
        rd("saturate_status", BASE + 14'd5, 16'hFF01);

        // Reset in the third cycle of a pulse
        mem_en = 1; mem_addr = 16'h0210;
        cycle();
        mem_en = 0;
        cycle(); cycle();
        chk("midpulse_rst_before", violation_rst, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_viol", violation_rst, 0);
        chk("async_rst_in_safe", in_safe_area, 0);
        chk("async_rst_irq", irq_violation, 0);
        for (int i = 0; i < 6; i++) rd("async_rst_regs", BASE + 14'(i), 16'h0000);
        @(negedge mclk);
        reset_n = 1'b1;
        mem_en = 1; mem_addr = 16'h0000; pc_valid = 1; pc = 16'h0000;
        repeat (3) cycle();
        chk("post_reset_disabled_rst", violation_rst, 0);
        chk("post_reset_disabled_in_safe", in_safe_area, 0);
        idle_inputs();

        // Randomized run against the model
        reset_n = 1'b0;
        repeat (2) cycle();
        model_reset();
        @(negedge mclk);
        reset_n = 1'b1;
        cycle();
        for (int it = 0; it < 4000; it++) begin
            int sel;
            idle_inputs();
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                int off;
                off = int'($urandom_range(0, 6));
                per_en = 1;
                per_we = 2'($urandom_range(1, 3));
                per_addr = BASE + 14'(off);
                case (off)
                    0: per_din = {13'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 5) != 0)};
                    1, 2: per_din = {8'h01, 8'($urandom)};
                    3, 4: per_din = {8'hE0, 8'($urandom)};
                    default: per_din = 16'($urandom);
                endcase
            end else if (sel == 1) begin
                per_en = 1;
                per_we = 2'b00;
                per_addr = BASE - 14'd1 + 14'($urandom_range(0, 7));
            end
            mem_en = ($urandom_range(0, 2) == 0);
            mem_addr = ($urandom_range(0, 2) != 0) ? {8'h01, 8'($urandom)} : 16'($urandom);
            pc_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: pc = m_clo;
                1, 2: pc = {8'hE0, 8'($urandom)};
                default: pc = 16'($urandom);
            endcase
            disable_debug = ($urandom_range(0, 7) == 0);
            #2;
            e_dout = m_read(per_addr, per_en, per_we);
            chk("rand_dout", per_dout, e_dout);
            model_edge();
            cycle();
            chk("rand_in_safe", in_safe_area, (m_mode == 2));
            chk("rand_viol_rst", violation_rst, m_exp_rst);
            chk("rand_irq", irq_violation, m_flag & m_irqen);
        end
        idle_inputs();
        per_en = 1; per_addr = BASE + 14'd5;
        #1;
        chk("rand_final_status", per_dout, m_read(BASE + 14'd5, 1'b1, 2'b00));
        per_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/safe_region_ctrl.md
Name: safe_region_ctrl

Overview:
- Programmable access-control controller for the protected (safe) memory region.
- Sits beside the CPU on the peripheral bus and holds the safe-data and safe-code bounds in software-writable, lockable registers.
- Sequences entry into and exit from the safe region through a single entry point, detects illegal data or code accesses, and issues a stretched violation reset.
- Keeps a violation flag, a saturating violation count and an interrupt.

Parameters:
- BASE_ADDR, 14'h0048: peripheral word address of register 0.
- RST_PULSE, 8: violation_rst width in mclk cycles; range 1..255.

Ports:
- mclk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access strobe.
- per_we  in  2  byte write enables; [0]=low byte, [1]=high byte.
- per_dout  out  16  peripheral read data.
- mem_addr  in  16  data memory byte address.
- mem_en  in  1  data memory access this cycle.
- pc  in  16  current instruction address.
- pc_valid  in  1  pc is a fetch this cycle.
- disable_debug  in  1  high suppresses violation_rst only.
- in_safe_area  out  1  CPU is legally executing safe code.
- violation_rst  out  1  reset request to the CPU.
- irq_violation  out  1  level interrupt.

Behaviour:
- Register map, at word offset from BASE_ADDR:
  - 0 CTRL: [0] EN, [1] LOCK, [2] IRQ_EN.
  - 1 SAFE_LO, 2 SAFE_HI: data bounds, inclusive.
  - 3 CODE_LO, 4 CODE_HI: code bounds, inclusive. CODE_LO is the only legal entry point.
  - 5 STATUS: [0] VIOL_FLAG, write 1 to clear. [1] write 1 to clear the count; reads 0. [15:8] VIOL_CNT.
- Register writes are byte-granular on per_en & per_we.
- Reads are combinational: per_dout = selected register when per_en & per_we==0 & address hits; otherwise per_dout = 0.
- LOCK is set-only. Once set, writes to CTRL[1:0] and to registers 1-4 are ignored until reset_n. IRQ_EN and STATUS stay writable.
- Ranges:
  - addr_in_safe = mem_en & SAFE_LO<=mem_addr<=SAFE_HI.
  - pc_in_code = pc_valid & CODE_LO<=pc<=CODE_HI.
  - If lo>hi the range is empty and never matches.
  - All compares are unsigned 16-bit.
- FSM, registered, 2-bit encoding:
  - DISABLED -> OUTSIDE when EN=1.
  - OUTSIDE:
    - addr_in_safe -> VIOL. This takes priority over entry in the same cycle.
    - else pc_valid & pc==CODE_LO -> INSIDE.
    - else pc_in_code, i.e. a mid-region jump -> VIOL.
  - INSIDE:
    - pc_valid & ~pc_in_code -> OUTSIDE.
    - Data accesses to the safe range are legal.
  - VIOL: entered with pulse counter loaded to RST_PULSE-1. Counts down each cycle. At 0 -> OUTSIDE.
- On entering VIOL:
  - Set VIOL_FLAG.
  - VIOL_CNT += 1, saturating at 255.
  - A same-cycle software clear of the count loses to the increment; the count becomes 1.
  - A same-cycle software clear of VIOL_FLAG loses to the set.
- Violations during VIOL are not counted again.
- EN=0, only writable while unlocked, forces DISABLED next cycle from any state and deasserts outputs immediately.
- Outputs, all registered except per_dout:
  - in_safe_area = (state==INSIDE).
  - violation_rst = (state==VIOL) & ~disable_debug. disable_debug does not stop counting or flagging.
  - irq_violation = VIOL_FLAG & IRQ_EN.
- First-cycle latencies:
  - violation_rst asserts the cycle after the offending access and lasts exactly RST_PULSE cycles.
  - in_safe_area asserts the cycle after the entry fetch.
- reset_n low: all registers 0, state DISABLED, all outputs 0. Reset mid-pulse terminates violation_rst asynchronously.

Decomposition:
- Shared package (smart_pkg):
  - FSM state encodings: DISABLED, OUTSIDE, INSIDE, VIOL.
  - Register offsets 0-5.
  - CTRL and STATUS bit positions.
- One sub-module, safe_region_regs: peripheral decode, byte writes, LOCK gating, read mux.
- The FSM, range compares and pulse counter stay in the top module.

Test Plan:
- Program SAFE 0x0200-0x02FF, CODE 0xE000-0xE0FF, EN=1. Data read at 0x0210 from OUTSIDE -> violation_rst high for 8 cycles starting next cycle, VIOL_FLAG=1, VIOL_CNT=1.
- Fetch 0xE000, then data access 0x0210 -> in_safe_area=1, no violation. Fetch 0x4400 -> in_safe_area=0 next cycle.
- From OUTSIDE, fetch 0xE010 -> violation. Same-cycle fetch 0xE000 plus data 0x0200 -> violation, not entry.
- Set LOCK, write SAFE_LO=0 and EN=0 -> both readback unchanged. Write STATUS=0x0001 -> flag cleared, irq_violation drops.
- disable_debug=1 and a violation -> violation_rst stays 0, VIOL_CNT increments. 256 violations -> VIOL_CNT=255.
- Assert reset_n low in cycle 3 of a pulse -> violation_rst=0 immediately, all registers 0, state DISABLED.
